// File: rtl/eth_tx_frame_arb.sv
// Round-robin frame arbiter: merges S_COUNT AXI-Stream byte sources into one MAC TX stream,
// holding the grant for a whole frame and truncating frames that exceed MAX_FRAME_LEN bytes.
module eth_tx_frame_arb #(
  parameter int S_COUNT       = 4,
  parameter int MAX_FRAME_LEN = 1522,
  localparam int IDX_W        = $clog2(S_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [S_COUNT*8-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]   s_axis_tvalid,
  output logic [S_COUNT-1:0]   s_axis_tready,
  input  logic [S_COUNT-1:0]   s_axis_tlast,
  input  logic [S_COUNT-1:0]   s_axis_tuser,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_index,
  output logic                 status_truncated
);

  localparam int CNT_W = ($clog2(MAX_FRAME_LEN + 1) > 12) ? $clog2(MAX_FRAME_LEN + 1) : 12;

  typedef enum logic [1:0] {IDLE, GRANT, DISCARD} state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   grant_index_reg;
  logic [IDX_W-1:0]   last_grant_reg;
  logic               grant_valid_reg;
  logic               status_truncated_reg;
  logic [CNT_W-1:0]   byte_cnt_reg;

  logic [IDX_W-1:0]   winner;
  logic [7:0]         sel_data;
  logic               sel_valid;
  logic               sel_last;
  logic               sel_user;
  logic               in_grant;
  logic               at_limit;
  logic               beat;

  function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int off);
    return IDX_W'((base + off) % S_COUNT);
  endfunction

  // Offset 1 from last_grant is visited last so it ends up with the highest priority.
  always_comb begin
    winner = last_grant_reg;
    for (int off = S_COUNT; off >= 1; off--) begin
      if (s_axis_tvalid[wrap_idx(int'(last_grant_reg), off)]) begin
        winner = wrap_idx(int'(last_grant_reg), off);
      end
    end
  end

  always_comb begin
    sel_data  = 8'h00;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_user  = 1'b0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (grant_index_reg == IDX_W'(i)) begin
        sel_data  = s_axis_tdata[i*8 +: 8];
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
        sel_user  = s_axis_tuser[i];
      end
    end
  end

  assign in_grant = (state_reg == GRANT);
  assign at_limit = (byte_cnt_reg == CNT_W'(MAX_FRAME_LEN - 1));
  assign beat     = m_axis_tvalid && m_axis_tready;

  // A beat at the byte limit without its own tlast becomes a forced, bad-marked frame end.
  assign m_axis_tdata  = in_grant ? sel_data : 8'h00;
  assign m_axis_tvalid = in_grant && sel_valid;
  assign m_axis_tlast  = in_grant && (sel_last || at_limit);
  assign m_axis_tuser  = in_grant && (sel_user || (at_limit && !sel_last));

  generate
    for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_ready
      assign s_axis_tready[gi] = (grant_index_reg == IDX_W'(gi)) &&
                                 ((in_grant && m_axis_tready) || (state_reg == DISCARD));
    end
  endgenerate

  assign grant_valid      = grant_valid_reg;
  assign grant_index      = grant_index_reg;
  assign status_truncated = status_truncated_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg            <= IDLE;
      grant_index_reg      <= '0;
      last_grant_reg       <= IDX_W'(S_COUNT - 1);
      grant_valid_reg      <= 1'b0;
      status_truncated_reg <= 1'b0;
      byte_cnt_reg         <= '0;
    end else begin
      status_truncated_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          byte_cnt_reg <= '0;
          if (|s_axis_tvalid) begin
            grant_index_reg <= winner;
            grant_valid_reg <= 1'b1;
            state_reg       <= GRANT;
          end
        end
        GRANT: begin
          if (beat) begin
            if (sel_last) begin
              last_grant_reg  <= grant_index_reg;
              grant_valid_reg <= 1'b0;
              byte_cnt_reg    <= '0;
              state_reg       <= IDLE;
            end else if (at_limit) begin
              status_truncated_reg <= 1'b1;
              byte_cnt_reg         <= '0;
              state_reg            <= DISCARD;
            end else begin
              byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
            end
          end
        end
        DISCARD: begin
          if (sel_valid && sel_last) begin
            last_grant_reg  <= grant_index_reg;
            grant_valid_reg <= 1'b0;
            state_reg       <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_frame_arb.sv
// Directed bench for eth_tx_frame_arb: a default-length instance and a MAX_FRAME_LEN=16
// instance share the same stimulus; each scenario checks the instance it targets.
module tb_eth_tx_frame_arb;

  logic        clk;
  logic        rst;
  logic [31:0] s_tdata;
  logic [3:0]  s_tvalid;
  logic [3:0]  s_tlast;
  logic [3:0]  s_tuser;
  logic        m_tready;

  logic [3:0] s_tready_a, s_tready_b;
  logic [7:0] m_tdata_a, m_tdata_b;
  logic       m_tvalid_a, m_tvalid_b, m_tlast_a, m_tlast_b, m_tuser_a, m_tuser_b;
  logic       gv_a, gv_b, trunc_a, trunc_b;
  logic [1:0] gidx_a, gidx_b;

  eth_tx_frame_arb #(.S_COUNT(4), .MAX_FRAME_LEN(1522)) dut_a (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_a),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata_a), .m_axis_tvalid(m_tvalid_a), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast_a), .m_axis_tuser(m_tuser_a),
    .grant_valid(gv_a), .grant_index(gidx_a), .status_truncated(trunc_a)
  );

  eth_tx_frame_arb #(.S_COUNT(4), .MAX_FRAME_LEN(16)) dut_b (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_b),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata_b), .m_axis_tvalid(m_tvalid_b), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast_b), .m_axis_tuser(m_tuser_b),
    .grant_valid(gv_b), .grant_index(gidx_b), .status_truncated(trunc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit sel_b = 1'b0;

  // Source models: requester i sends frames of src_len[i] bytes, byte k = src_base[i] + k.
  int         src_len[4];
  int         src_ptr[4];
  int         src_frames[4];
  bit         src_en[4];
  bit         src_ulast[4];
  logic [7:0] src_base[4];

  logic [7:0] o_data;
  logic       o_mvalid, o_last, o_user, o_gv, o_trunc, o_fire;
  logic [1:0] o_gidx;
  logic [3:0] o_sready;

  task automatic clear_sources();
    for (int i = 0; i < 4; i++) begin
      src_len[i] = 1; src_ptr[i] = 0; src_frames[i] = 0;
      src_en[i] = 1'b0; src_ulast[i] = 1'b0; src_base[i] = 8'(i * 16);
    end
  endtask

  task automatic set_src(input int i, input int len, input int frames);
    src_len[i] = len; src_ptr[i] = 0; src_frames[i] = frames; src_en[i] = 1'b1;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < 4; i++) begin
      s_tvalid[i]        = src_en[i] && (src_frames[i] > 0);
      s_tdata[i*8 +: 8]  = src_base[i] + 8'(src_ptr[i]);
      s_tlast[i]         = s_tvalid[i] && (src_ptr[i] == src_len[i] - 1);
      s_tuser[i]         = s_tlast[i] && src_ulast[i];
    end
  endtask

  // One clock: drive, sample on the falling edge, then advance sources that handshook.
  task automatic tick();
    logic [3:0] fire;
    drive_inputs();
    @(negedge clk);
    o_data   = sel_b ? m_tdata_b  : m_tdata_a;
    o_mvalid = sel_b ? m_tvalid_b : m_tvalid_a;
    o_last   = sel_b ? m_tlast_b  : m_tlast_a;
    o_user   = sel_b ? m_tuser_b  : m_tuser_a;
    o_gv     = sel_b ? gv_b       : gv_a;
    o_gidx   = sel_b ? gidx_b     : gidx_a;
    o_trunc  = sel_b ? trunc_b    : trunc_a;
    o_sready = sel_b ? s_tready_b : s_tready_a;
    o_fire   = o_mvalid && m_tready;
    fire     = s_tvalid & o_sready;
    if (o_fire && o_last)
      $display("frame end: req=%0d data=%02h user=%0b", o_gidx, o_data, o_user);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (fire[i]) begin
        if (src_ptr[i] == src_len[i] - 1) begin
          src_ptr[i] = 0;
          src_frames[i] = src_frames[i] - 1;
        end else begin
          src_ptr[i] = src_ptr[i] + 1;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; m_tready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    clear_sources();
  endtask

  task automatic test_reset();
    sel_b = 1'b0; rst = 1'b1; m_tready = 1'b1;
    clear_sources();
    for (int i = 0; i < 4; i++) set_src(i, 3, 1);
    tick(); tick();
    total++; if (o_gv !== 1'b0) begin bad++; $display("FAIL rst_gv: got %0b want 0", o_gv); end
    total++; if (o_gidx !== 2'd0) begin bad++; $display("FAIL rst_gidx: got %0d want 0", o_gidx); end
    total++; if (o_mvalid !== 1'b0) begin bad++; $display("FAIL rst_mvalid: got %0b want 0", o_mvalid); end
    total++; if (o_last !== 1'b0 || o_user !== 1'b0) begin bad++; $display("FAIL rst_last_user: got %0b%0b want 00", o_last, o_user); end
    total++; if (o_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %02h want 00", o_data); end
    total++; if (o_sready !== 4'b0000) begin bad++; $display("FAIL rst_sready: got %b want 0000", o_sready); end
    total++; if (o_trunc !== 1'b0) begin bad++; $display("FAIL rst_trunc: got %0b want 0", o_trunc); end
    total++; if (gv_b !== 1'b0 || m_tvalid_b !== 1'b0) begin bad++; $display("FAIL rst_b: got gv=%0b mv=%0b want 0 0", gv_b, m_tvalid_b); end
    rst = 1'b0;
    clear_sources();
  endtask

  // Four sources with 3-byte frames, requester 0 has two: order 0,1,2,3,0, one idle cycle apart.
  task automatic test_round_robin();
    int exp_req[5] = '{0, 1, 2, 3, 0};
    int nb, f, k;
    sel_b = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) set_src(i, 3, (i == 0) ? 2 : 1);
    nb = 0;
    for (int c = 0; c < 40 && nb < 15; c++) begin
      tick();
      if (o_fire) begin
        f = nb / 3; k = nb % 3;
        total++; if (o_data !== 8'(exp_req[f] * 16 + k)) begin bad++; $display("FAIL rr_data: beat %0d got %02h want %02h", nb, o_data, 8'(exp_req[f] * 16 + k)); end
        total++; if (o_gidx !== 2'(exp_req[f])) begin bad++; $display("FAIL rr_gidx: beat %0d got %0d want %0d", nb, o_gidx, exp_req[f]); end
        total++; if (o_last !== 1'(k == 2)) begin bad++; $display("FAIL rr_last: beat %0d got %0b want %0b", nb, o_last, (k == 2)); end
        total++; if (c != 1 + 4 * f + k) begin bad++; $display("FAIL rr_timing: beat %0d at cycle %0d want %0d", nb, c, 1 + 4 * f + k); end
        nb++;
      end
    end
    total++; if (nb != 15) begin bad++; $display("FAIL rr_count: got %0d beats want 15", nb); end
  endtask

  // Requester 2 sends 70 bytes; requester 0 appears at beat 10 and must wait for the tlast.
  task automatic test_lock();
    int nb, k, req, len;
    sel_b = 1'b0;
    do_reset();
    set_src(2, 70, 1);
    set_src(0, 3, 1);
    src_en[0] = 1'b0;
    nb = 0;
    for (int c = 0; c < 200 && nb < 73; c++) begin
      if (!src_en[0] && src_ptr[2] >= 10) src_en[0] = 1'b1;
      tick();
      if (o_gv && o_gidx == 2'd2) begin
        total++; if (o_sready[0] !== 1'b0) begin bad++; $display("FAIL lock_sready0: got %0b want 0 at cycle %0d", o_sready[0], c); end
      end
      if (o_fire) begin
        req = (nb < 70) ? 2 : 0; k = (nb < 70) ? nb : nb - 70; len = (nb < 70) ? 70 : 3;
        total++; if (o_gidx !== 2'(req) || o_data !== 8'(req * 16 + k)) begin bad++; $display("FAIL lock_beat: beat %0d got req %0d data %02h want req %0d data %02h", nb, o_gidx, o_data, req, 8'(req * 16 + k)); end
        total++; if (o_last !== 1'(k == len - 1)) begin bad++; $display("FAIL lock_last: beat %0d got %0b want %0b", nb, o_last, (k == len - 1)); end
        nb++;
      end
    end
    total++; if (nb != 73) begin bad++; $display("FAIL lock_count: got %0d beats want 73", nb); end
  endtask

  // MAX_FRAME_LEN=16 instance: 20-byte frame is cut at 16 and the remaining 4 beats are absorbed.
  task automatic test_truncate();
    int nb, pulses;
    sel_b = 1'b1;
    do_reset();
    set_src(1, 20, 1);
    nb = 0; pulses = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (o_trunc) pulses++;
      if (o_fire) begin
        total++; if (o_data !== 8'(16 + nb)) begin bad++; $display("FAIL trunc_data: beat %0d got %02h want %02h", nb, o_data, 8'(16 + nb)); end
        total++; if (o_last !== 1'(nb == 15) || o_user !== 1'(nb == 15)) begin bad++; $display("FAIL trunc_flags: beat %0d got last=%0b user=%0b want %0b", nb, o_last, o_user, (nb == 15)); end
        nb++;
      end
    end
    total++; if (nb != 16) begin bad++; $display("FAIL trunc_count: got %0d beats want 16", nb); end
    total++; if (pulses != 1) begin bad++; $display("FAIL trunc_pulse: got %0d pulses want 1", pulses); end
    total++; if (src_frames[1] != 0) begin bad++; $display("FAIL trunc_absorb: source left %0d frames at byte %0d want 0", src_frames[1], src_ptr[1]); end
    total++; if (o_gv !== 1'b0) begin bad++; $display("FAIL trunc_gv: got %0b want 0", o_gv); end
    sel_b = 1'b0;
  endtask

  // m_axis_tready toggles every cycle on a 5-byte frame while the others wait.
  task automatic test_stall();
    int n0;
    bit done;
    sel_b = 1'b0;
    do_reset();
    set_src(0, 5, 1);
    for (int i = 1; i < 4; i++) set_src(i, 4, 1);
    n0 = 0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      m_tready = (c % 2 == 0);
      tick();
      if (o_gv && o_gidx == 2'd0) begin
        total++; if (o_sready[3:1] !== 3'b000) begin bad++; $display("FAIL stall_sready: got %b want 000 at cycle %0d", o_sready[3:1], c); end
      end
      if (o_fire) begin
        if (o_gidx == 2'd0) begin
          total++; if (o_data !== 8'(n0) || o_last !== 1'(n0 == 4)) begin bad++; $display("FAIL stall_beat: beat %0d got %02h last %0b want %02h last %0b", n0, o_data, o_last, 8'(n0), (n0 == 4)); end
          n0++;
        end else begin
          done = 1'b1;
          total++; if (o_gidx !== 2'd1) begin bad++; $display("FAIL stall_next: got req %0d want 1", o_gidx); end
        end
      end
    end
    total++; if (n0 != 5) begin bad++; $display("FAIL stall_count: got %0d beats want 5", n0); end
    total++; if (!done) begin bad++; $display("FAIL stall_timeout: got no next frame want one"); end
    m_tready = 1'b1;
  endtask

  // Requester 1 drops tvalid for 3 cycles mid-frame; requester 3 must not steal the grant.
  task automatic test_valid_drop();
    int nb, hold, req, k;
    sel_b = 1'b0;
    do_reset();
    set_src(1, 5, 1);
    set_src(3, 2, 1);
    nb = 0; hold = 0;
    for (int c = 0; c < 40 && nb < 7; c++) begin
      if (src_ptr[1] == 2 && src_frames[1] > 0 && hold < 3) begin
        src_en[1] = 1'b0; hold++;
      end else begin
        src_en[1] = 1'b1;
      end
      tick();
      if (!src_en[1]) begin
        total++; if (o_gv !== 1'b1 || o_gidx !== 2'd1) begin bad++; $display("FAIL drop_hold: got gv=%0b req=%0d want 1 1", o_gv, o_gidx); end
      end
      if (o_fire) begin
        req = (nb < 5) ? 1 : 3; k = (nb < 5) ? nb : nb - 5;
        total++; if (o_gidx !== 2'(req) || o_data !== 8'(req * 16 + k)) begin bad++; $display("FAIL drop_beat: beat %0d got req %0d data %02h want req %0d data %02h", nb, o_gidx, o_data, req, 8'(req * 16 + k)); end
        nb++;
      end
    end
    total++; if (nb != 7) begin bad++; $display("FAIL drop_count: got %0d beats want 7", nb); end
  endtask

  // Reset at beat 3 of requester 3's frame (after requester 0 was served): outputs clear, 0 wins next.
  task automatic test_reset_mid();
    int lasts3;
    bit reached, seen;
    sel_b = 1'b0;
    do_reset();
    set_src(0, 2, 1);
    set_src(3, 10, 1);
    lasts3 = 0; reached = 1'b0;
    for (int c = 0; c < 40 && !reached; c++) begin
      tick();
      if (o_fire && o_last && o_gidx == 2'd3) lasts3++;
      if (src_ptr[3] == 3) reached = 1'b1;
    end
    total++; if (!reached) begin bad++; $display("FAIL rmid_reach: got ptr %0d want 3", src_ptr[3]); end
    rst = 1'b1;
    tick();
    if (o_fire && o_last && o_gidx == 2'd3) lasts3++;
    tick();
    total++; if (lasts3 != 0) begin bad++; $display("FAIL rmid_tlast: got %0d tlast beats want 0", lasts3); end
    total++; if (o_gv !== 1'b0 || o_gidx !== 2'd0) begin bad++; $display("FAIL rmid_grant: got gv=%0b req=%0d want 0 0", o_gv, o_gidx); end
    total++; if (o_mvalid !== 1'b0 || o_last !== 1'b0 || o_user !== 1'b0 || o_data !== 8'h00) begin bad++; $display("FAIL rmid_m: got v=%0b l=%0b u=%0b d=%02h want 0 0 0 00", o_mvalid, o_last, o_user, o_data); end
    total++; if (o_sready !== 4'b0000) begin bad++; $display("FAIL rmid_sready: got %b want 0000", o_sready); end
    rst = 1'b0;
    clear_sources();
    set_src(0, 3, 1);
    set_src(3, 3, 1);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (c == 0) begin
        total++; if (o_mvalid !== 1'b0) begin bad++; $display("FAIL rmid_idle: got mvalid %0b want 0", o_mvalid); end
      end
      if (o_fire) begin
        seen = 1'b1;
        total++; if (o_gidx !== 2'd0 || o_data !== 8'h00) begin bad++; $display("FAIL rmid_first: got req %0d data %02h want req 0 data 00", o_gidx, o_data); end
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL rmid_timeout: got no beat want one"); end
  endtask

  // tuser on the last beat passes straight through with no truncation pulse.
  task automatic test_tuser();
    int nb, pulses;
    sel_b = 1'b0;
    do_reset();
    set_src(2, 4, 1);
    src_ulast[2] = 1'b1;
    nb = 0; pulses = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (o_trunc) pulses++;
      if (o_fire) begin
        total++; if (o_user !== 1'(nb == 3) || o_last !== 1'(nb == 3)) begin bad++; $display("FAIL tuser_flags: beat %0d got user=%0b last=%0b want %0b", nb, o_user, o_last, (nb == 3)); end
        nb++;
      end
    end
    total++; if (nb != 4) begin bad++; $display("FAIL tuser_count: got %0d beats want 4", nb); end
    total++; if (pulses != 0) begin bad++; $display("FAIL tuser_trunc: got %0d pulses want 0", pulses); end
  endtask

  initial begin
    rst = 1'b1; m_tready = 1'b1;
    s_tdata = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0;
    clear_sources();
    test_reset();
    test_round_robin();
    test_lock();
    test_truncate();
    test_stall();
    test_valid_drop();
    test_reset_mid();
    test_tuser();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_tx_frame_arb.md
ETH_TX_FRAME_ARB -- requirements
Module: eth_tx_frame_arb

Interface
REQ-001 SHALL have parameter S_COUNT, default 4, number of requesting AXI-Stream inputs (legal 2..8).
REQ-002 SHALL have parameter MAX_FRAME_LEN, default 1522, byte limit per frame before forced truncation.
REQ-003 SHALL have port clk, input, 1, the single clock (logic clock domain of the MAC FIFO TX side).
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have ports s_axis_tdata input S_COUNT*8, s_axis_tvalid input S_COUNT, s_axis_tready output S_COUNT, s_axis_tlast input S_COUNT, s_axis_tuser input S_COUNT; slice i is requester i.
REQ-006 SHALL have ports m_axis_tdata output 8, m_axis_tvalid output 1, m_axis_tready input 1, m_axis_tlast output 1, m_axis_tuser output 1, driving the MAC TX FIFO.
REQ-007 SHALL have port grant_valid output 1, high while a frame is granted.
REQ-008 SHALL have port grant_index output $clog2(S_COUNT), index of the granted requester.
REQ-009 SHALL have port status_truncated output 1, a one-cycle pulse when a frame is cut at MAX_FRAME_LEN.

Function
REQ-010 SHALL implement FSM states IDLE, GRANT, DISCARD.
REQ-011 IDLE: when any s_axis_tvalid is high, SHALL register the round-robin winner into grant_index, set grant_valid, and enter GRANT on the next edge; no data passes in the IDLE cycle (1-cycle arbitration latency).
REQ-012 Round-robin: search starts at (last_grant+1) mod S_COUNT; last_grant resets to S_COUNT-1 so requester 0 wins first.
REQ-013 GRANT: m_axis_* SHALL combinationally mirror the granted slice; s_axis_tready[grant_index] = m_axis_tready; every other s_axis_tready SHALL be 0.
REQ-014 A beat transfers when m_axis_tvalid and m_axis_tready are both high; a 12-bit (min) byte counter SHALL increment per beat and clear on frame end.
REQ-015 On a transfer with tlast=1 in GRANT: SHALL update last_grant, clear grant_valid, return to IDLE; the next grant cannot begin before the following cycle.
REQ-016 Grant SHALL be locked for the whole frame; other requesters' tvalid never preempts.
REQ-017 If a beat transfers at byte count MAX_FRAME_LEN-1 without tlast: SHALL force m_axis_tlast=1 and m_axis_tuser=1 on that beat, pulse status_truncated, enter DISCARD.
REQ-018 DISCARD: m_axis_tvalid=0; s_axis_tready[grant_index]=1; beats are dropped until a beat with tlast=1, then IDLE with last_grant updated.
REQ-019 tuser SHALL pass through unchanged in GRANT (bad-frame marking is honored downstream).
REQ-020 Stalls (m_axis_tready=0) SHALL hold the state, counter and grant indefinitely.
REQ-021 A requester dropping tvalid mid-frame SHALL NOT release the grant.
REQ-022 With S_COUNT requesters all continuously valid, each SHALL receive exactly one frame per S_COUNT frames.

Reset
REQ-023 While rst=1 at a clock edge: state=IDLE, grant_valid=0, grant_index=0, last_grant=S_COUNT-1, counter=0, status_truncated=0.
REQ-024 Outputs during/after reset: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, all s_axis_tready=0; m_axis_tdata=0.
REQ-025 Reset mid-frame SHALL abandon the frame with no tlast emitted; the next frame starts fresh from IDLE.

Verification
REQ-026 All 4 inputs valid with 3-byte frames, m_axis_tready=1 -> output order 0,1,2,3,0; one idle cycle between frames; grant_index matches.
REQ-027 Input 2 sends 70-byte frame, input 0 raises tvalid at beat 10 -> frame 2 output contiguous, input 0 granted after its tlast.
REQ-028 MAX_FRAME_LEN=16, input 1 sends 20 bytes -> 16 beats out, beat 16 tlast=1 tuser=1, status_truncated one pulse, 4 beats absorbed, grant_valid low afterwards.
REQ-029 m_axis_tready toggled 1/0 every cycle on a 5-byte frame -> exactly 5 beats, data in order, s_axis_tready of non-granted inputs always 0.
REQ-030 rst asserted at beat 3 of a 10-byte frame from input 3 -> next cycle all outputs at reset values; after release requester 0 wins first.
REQ-031 Input tuser=1 on last beat of a frame -> m_axis_tuser=1 on the same beat, no truncation pulse.
